// File: rtl/player_sprite.sv
// Player sprite: per-frame jump/gravity physics and horizontal movement,
// plus a registered per-pixel coverage flag for the colour mux.
module player_sprite #(
    parameter int X_INIT   = 320,
    parameter int Y_FLOOR  = 400,
    parameter int SIZE     = 16,
    parameter int STEP     = 2,
    parameter int X_MIN    = 8,
    parameter int X_MAX    = 616,
    parameter int JUMP_V   = 10,
    parameter int GRAV     = 1,
    parameter int MAX_FALL = 12
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] h_i,
    input  logic [15:0] v_i,
    input  logic        active_i,
    input  logic        frame_i,
    input  logic        btn_left_i,
    input  logic        btn_right_i,
    input  logic        btn_jump_i,
    output logic [15:0] player_x_o,
    output logic [15:0] player_y_o,
    output logic        airborne_o,
    output logic        land_o,
    output logic        pixel_on_o
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    localparam logic [15:0] XI    = 16'(X_INIT);
    localparam logic [15:0] YF    = 16'(Y_FLOOR);
    localparam logic [15:0] SZ1   = 16'(SIZE - 1);
    localparam logic [15:0] STP   = 16'(STEP);
    localparam logic [15:0] XMIN  = 16'(X_MIN);
    localparam logic [15:0] XMAX  = 16'(X_MAX);
    localparam logic [15:0] JV    = 16'(JUMP_V);
    localparam logic [15:0] GR    = 16'(GRAV);
    localparam logic [15:0] MF    = 16'(MAX_FALL);
    localparam logic [15:0] LO_TH = 16'(X_MIN + STEP);
    localparam logic [15:0] HI_TH = 16'(X_MAX - STEP);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] spd_q, spd_d;
    logic        jprev_q, jprev_d;
    logic        land_q, land_d;
    logic        pix_q, pix_d;
    logic [1:0]  l_sync_q, r_sync_q, j_sync_q;

    logic        left, right, jump;
    logic [15:0] ny;
    logic [15:0] spd_up;

    assign left   = l_sync_q[1];
    assign right  = r_sync_q[1];
    assign jump   = j_sync_q[1];
    assign ny     = y_q + spd_q;
    assign spd_up = spd_q + GR;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        spd_d   = spd_q;
        jprev_d = jprev_q;
        land_d  = 1'b0;
        if (frame_i) begin
            jprev_d = jump;
            // Compare before subtracting so x never wraps below zero.
            if (left && !right) begin
                x_d = (x_q < LO_TH) ? XMIN : x_q - STP;
            end else if (right && !left) begin
                x_d = (x_q > HI_TH) ? XMAX : x_q + STP;
            end
            unique case (state_q)
                GROUND: begin
                    y_d = YF;
                    if (jump && !jprev_q) begin
                        state_d = RISE;
                        spd_d   = JV;
                    end
                end
                RISE: begin
                    y_d = y_q - spd_q;
                    if (spd_q <= GR) begin
                        spd_d   = '0;
                        state_d = FALL;
                    end else begin
                        spd_d = spd_q - GR;
                    end
                end
                FALL: begin
                    if (ny >= YF) begin
                        y_d     = YF;
                        spd_d   = '0;
                        state_d = GROUND;
                        land_d  = 1'b1;
                    end else begin
                        y_d   = ny;
                        spd_d = (spd_up > MF) ? MF : spd_up;
                    end
                end
                default: state_d = GROUND;
            endcase
        end
    end

    always_comb begin
        pix_d = active_i
              && (h_i >= x_q) && (h_i <= x_q + SZ1)
              && (v_i >= y_q) && (v_i <= y_q + SZ1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= GROUND;
            x_q      <= XI;
            y_q      <= YF;
            spd_q    <= '0;
            jprev_q  <= 1'b0;
            land_q   <= 1'b0;
            pix_q    <= 1'b0;
            l_sync_q <= '0;
            r_sync_q <= '0;
            j_sync_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            spd_q    <= spd_d;
            jprev_q  <= jprev_d;
            land_q   <= land_d;
            pix_q    <= pix_d;
            l_sync_q <= {l_sync_q[0], btn_left_i};
            r_sync_q <= {r_sync_q[0], btn_right_i};
            j_sync_q <= {j_sync_q[0], btn_jump_i};
        end
    end

    assign player_x_o = x_q;
    assign player_y_o = y_q;
    assign airborne_o = (state_q != GROUND);
    assign land_o     = land_q;
    assign pixel_on_o = pix_q;

endmodule

// File: tb/tb_player_sprite.sv
// Bench for player_sprite: directed and random frames checked against
// a signed-velocity physics model, plus a partial raster coverage scan.
module tb_player_sprite;

    localparam int X_INIT   = 320;
    localparam int Y_FLOOR  = 400;
    localparam int SIZE     = 16;
    localparam int STEP     = 2;
    localparam int X_MIN    = 8;
    localparam int X_MAX    = 616;
    localparam int JUMP_V   = 10;
    localparam int GRAV     = 1;
    localparam int MAX_FALL = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] h = '0;
    logic [15:0] v = '0;
    logic        active = 1'b0;
    logic        frame = 1'b0;
    logic        bl = 1'b0;
    logic        br = 1'b0;
    logic        bj = 1'b0;
    logic [15:0] px, py;
    logic        air, land, pix;

    player_sprite dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .h_i         (h),
        .v_i         (v),
        .active_i    (active),
        .frame_i     (frame),
        .btn_left_i  (bl),
        .btn_right_i (br),
        .btn_jump_i  (bj),
        .player_x_o  (px),
        .player_y_o  (py),
        .airborne_o  (air),
        .land_o      (land),
        .pixel_on_o  (pix)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: vel < 0 is upward motion, vel >= 0 while airborne is falling.
    int mx = X_INIT;
    int my = Y_FLOOR;
    int mvel = 0;
    int mair = 0;
    int mprev = 0;
    int last_land = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mx = X_INIT;
        my = Y_FLOOR;
        mvel = 0;
        mair = 0;
        mprev = 0;
    endtask

    task automatic model_frame(input int l, input int r, input int j,
                               output int landed);
        landed = 0;
        if (l != 0 && r == 0)
            mx = (mx - STEP < X_MIN) ? X_MIN : mx - STEP;
        if (r != 0 && l == 0)
            mx = (mx + STEP > X_MAX) ? X_MAX : mx + STEP;
        if (mair == 0) begin
            if (j != 0 && mprev == 0) begin
                mair = 1;
                mvel = -JUMP_V;
            end
        end else if (mvel < 0) begin
            my = my + mvel;
            mvel = mvel + GRAV;
            if (mvel > 0) mvel = 0;
        end else if (my + mvel >= Y_FLOOR) begin
            my = Y_FLOOR;
            mvel = 0;
            mair = 0;
            landed = 1;
        end else begin
            my = my + mvel;
            mvel = (mvel + GRAV > MAX_FALL) ? MAX_FALL : mvel + GRAV;
        end
        mprev = j;
    endtask

    task automatic do_frame(input int l, input int r, input int j);
        int landed;
        bl = l[0];
        br = r[0];
        bj = j[0];
        repeat (3) tick();
        frame = 1'b1;
        tick();
        frame = 1'b0;
        model_frame(l, r, j, landed);
        last_land = int'(land);
        chk("x", int'(px), mx);
        chk("y", int'(py), my);
        chk("airborne", int'(air), mair);
        chk("land", int'(land), landed);
        tick();
        chk("land_width", int'(land), 0);
    endtask

    task automatic pix_step(input int hh, input int vv, input int act);
        int exp;
        h = 16'(hh);
        v = 16'(vv);
        active = act[0];
        tick();
        exp = (act != 0 && hh >= mx && hh <= mx + SIZE - 1
               && vv >= my && vv <= my + SIZE - 1) ? 1 : 0;
        chk("pixel_on", int'(pix), exp);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_x", int'(px), 320);
        chk("rst_y", int'(py), 400);
        chk("rst_air", int'(air), 0);
        chk("rst_land", int'(land), 0);
        chk("rst_pix", int'(pix), 0);
        rst_n = 1'b1;
        tick();

        repeat (3) do_frame(0, 0, 0);
        chk("idle_x", int'(px), 320);
        chk("idle_y", int'(py), 400);

        repeat (10) do_frame(0, 1, 0);
        chk("right10", int'(px), 340);
        repeat (200) do_frame(1, 0, 0);
        chk("left_clamp", int'(px), 8);
        repeat (20) do_frame(0, 1, 0);
        repeat (5) do_frame(1, 1, 0);
        chk("both_hold", int'(px), 48);

        do_frame(0, 0, 1);
        chk("jump_air", int'(air), 1);
        repeat (10) do_frame(0, 0, 0);
        chk("apex_y", int'(py), 345);
        repeat (10) do_frame(0, 0, 0);
        chk("fall10_air", int'(air), 1);
        do_frame(0, 0, 0);
        chk("land11_pulse", last_land, 1);
        chk("land11_y", int'(py), 400);
        chk("land11_air", int'(air), 0);

        repeat (30) do_frame(0, 0, 1);
        chk("held_no_rejump", int'(air), 0);
        do_frame(0, 0, 0);
        do_frame(0, 0, 1);
        chk("second_jump", int'(air), 1);
        for (int i = 0; i < 40 && mair != 0; i++) do_frame(0, 0, 0);

        for (int i = 0; i < 200 && mx != 320; i++) do_frame(0, 1, 0);
        chk("raster_x", int'(px), 320);
        for (int vv = 396; vv < 420; vv++)
            for (int hh = 316; hh < 340; hh++)
                pix_step(hh, vv, ($urandom_range(0, 3) != 0) ? 1 : 0);
        for (int hh = 318; hh < 338; hh++) pix_step(hh, 405, 0);
        pix_step(0, 0, 1);
        pix_step(799, 524, 1);
        active = 1'b0;

        for (int i = 0; i < 300; i++)
            do_frame(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? 1 : 0);

        for (int i = 0; i < 40 && mair != 0; i++) do_frame(0, 0, 0);
        do_frame(0, 0, 1);
        do_frame(0, 0, 0);
        do_frame(0, 0, 0);
        chk("mid_rise_air", int'(air), 1);
        h = 16'(mx);
        v = 16'(my);
        active = 1'b1;
        tick();
        chk("pre_rst_pix", int'(pix), 1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_x", int'(px), 320);
        chk("arst_y", int'(py), 400);
        chk("arst_air", int'(air), 0);
        chk("arst_pix", int'(pix), 0);
        chk("arst_land", int'(land), 0);
        active = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        repeat (3) do_frame(0, 0, 0);
        chk("post_rst_air", int'(air), 0);
        chk("post_rst_y", int'(py), 400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
